// File: rtl/load_store_unit.sv
// RV32I memory-access stage: effective-address generation, held data_memory request, load writeback and faults.
// Optional alignment trap enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            or_ready,
  input  logic            i_is_load,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_base,
  input  logic [XLEN-1:0] i_offset,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic [XLEN-1:0] or_mem_data,
  output logic [2:0]      or_mem_funct3,
  output logic            or_mem_read_write,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            or_wb_valid,
  output logic [4:0]      or_wb_rd,
  output logic [XLEN-1:0] or_wb_data,
  output logic            or_done,
  output logic            or_fault,
  output logic [1:0]      or_fault_cause,
  output logic [XLEN-1:0] or_fault_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic              is_load_q, is_load_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;

  logic [XLEN-1:0]   eff_addr;
  logic              illegal_f3;
  logic              misaligned;
  logic              timeout_hit;

  assign eff_addr   = i_base + i_offset;
  assign illegal_f3 = i_is_load ? ((i_funct3 == 3'b011) || (i_funct3[2:1] == 2'b11))
                                : (i_funct3 >= 3'b011);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((i_funct3[1:0] == 2'b01) && eff_addr[0]) ||
                      ((i_funct3[1:0] == 2'b10) && (eff_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // A zero TIMEOUT_CYCLES disables the abort; the counter then simply wraps.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    funct3_d  = funct3_q;
    rd_d      = rd_q;
    is_load_d = is_load_q;
    cause_d   = cause_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          addr_d    = eff_addr;
          data_d    = i_store_data;
          funct3_d  = i_funct3;
          rd_d      = i_rd;
          is_load_d = i_is_load;
          cnt_d     = '0;
          if (illegal_f3) begin
            cause_d = CAUSE_ILLEGAL;
            state_d = S_FAULT;
          end else if (misaligned) begin
            cause_d = CAUSE_MISALIGN;
            state_d = S_FAULT;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_mem_ack) begin
          if (is_load_q) wb_data_d = i_mem_data;
          state_d = S_DONE;
        end else if (timeout_hit) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = S_FAULT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      funct3_q  <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
      cause_q   <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      funct3_q  <= funct3_d;
      rd_q      <= rd_d;
      is_load_q <= is_load_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign or_ready          = (state_q == S_IDLE);
  assign or_mem_req        = (state_q == S_REQ);
  assign or_mem_addr       = addr_q;
  assign or_mem_data       = data_q;
  assign or_mem_funct3     = funct3_q;
  assign or_mem_read_write = is_load_q;
  assign or_wb_valid       = (state_q == S_DONE) && is_load_q;
  assign or_wb_rd          = rd_q;
  assign or_wb_data        = wb_data_q;
  assign or_done           = (state_q == S_DONE) || (state_q == S_FAULT);
  assign or_fault          = (state_q == S_FAULT);
  assign or_fault_cause    = (state_q == S_FAULT) ? cause_q : 2'b00;
  assign or_fault_addr     = (state_q == S_FAULT) ? addr_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes model results, monitor pops on or_done.
module tb_load_store_unit;

  localparam int TO = 16;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_is_load, i_mem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_base, i_offset, i_store_data, i_mem_data;
  logic [4:0]  i_rd;
  logic        or_ready, or_mem_req, or_mem_read_write, or_wb_valid, or_done, or_fault;
  logic [31:0] or_mem_addr, or_mem_data, or_wb_data, or_fault_addr;
  logic [2:0]  or_mem_funct3;
  logic [4:0]  or_wb_rd;
  logic [1:0]  or_fault_cause;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .or_ready(or_ready),
    .i_is_load(i_is_load), .i_funct3(i_funct3), .i_base(i_base), .i_offset(i_offset),
    .i_store_data(i_store_data), .i_rd(i_rd), .or_mem_req(or_mem_req),
    .or_mem_addr(or_mem_addr), .or_mem_data(or_mem_data), .or_mem_funct3(or_mem_funct3),
    .or_mem_read_write(or_mem_read_write), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .or_wb_valid(or_wb_valid), .or_wb_rd(or_wb_rd), .or_wb_data(or_wb_data),
    .or_done(or_done), .or_fault(or_fault), .or_fault_cause(or_fault_cause),
    .or_fault_addr(or_fault_addr)
  );

  typedef struct {
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] addr;
    logic        wbv;
    logic [4:0]  rd;
    logic [31:0] wbd;
    int          req;
    int          cyc;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] sdata;
  } exp_t;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 1;
  logic [31:0] mem_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: address arithmetic, legality and alignment from the ISA rules;
  // the op occupies accept cycle + REQ cycles + one retire cycle.
  function automatic exp_t model(input logic ld, input logic [2:0] f3, input logic [31:0] base,
                                 input logic [31:0] off, input logic [31:0] sd,
                                 input logic [4:0] rd, input int delay, input logic [31:0] md);
    exp_t e;
    int   size;
    bit   illegal, mis;
    e.addr  = base + off;
    e.rw    = ld;
    e.f3    = f3;
    e.sdata = sd;
    e.rd    = rd;
    e.fault = 1'b0;
    e.cause = 2'b00;
    e.wbv   = 1'b0;
    e.wbd   = '0;
    e.req   = 0;
    size    = 1 << (f3 % 4);
    illegal = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
`ifdef MISALIGN_TRAP_EN
    mis = (e.addr % size) != 0;
`else
    mis = 1'b0;
`endif
    if (illegal) begin
      e.fault = 1'b1; e.cause = 2'b10;
    end else if (mis) begin
      e.fault = 1'b1; e.cause = 2'b01;
    end else if (delay > TO) begin
      e.fault = 1'b1; e.cause = 2'b11; e.req = TO;
    end else begin
      e.req = delay; e.wbv = ld; e.wbd = md;
    end
    e.cyc = e.req + 2;
    return e;
  endfunction

  // Memory responder: acks on the ack_delay-th REQ cycle.
  int reqcnt = 0;
  always @(negedge clk) begin
    if (rst_n && or_mem_req) begin
      reqcnt++;
      i_mem_ack  = (reqcnt == ack_delay);
      i_mem_data = i_mem_ack ? mem_rdata : $urandom;
    end else begin
      reqcnt     = 0;
      i_mem_ack  = 1'b0;
      i_mem_data = $urandom;
    end
  end

  // Monitor: request stability while REQ, full retire check on or_done.
  logic prev_ready = 1'b1;
  int   opcyc = 0;
  int   reqc = 0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ready = 1'b1;
      opcyc = 0;
      reqc = 0;
    end else begin
      if (prev_ready && !or_ready) begin
        opcyc = 1;
        reqc = 0;
      end else begin
        opcyc++;
      end
      if (or_mem_req && sbq.size() > 0) begin
        reqc++;
        chk("req_addr", or_mem_addr, sbq[0].addr);
        chk("req_rw", 32'(or_mem_read_write), 32'(sbq[0].rw));
        chk("req_f3", 32'(or_mem_funct3), 32'(sbq[0].f3));
        chk("req_data", or_mem_data, sbq[0].sdata);
        chk("req_ready", 32'(or_ready), 32'd0);
      end
      if (or_done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          me = sbq.pop_front();
          chk("fault", 32'(or_fault), 32'(me.fault));
          chk("cause", 32'(or_fault_cause), 32'(me.cause));
          if (me.fault) chk("fault_addr", or_fault_addr, me.addr);
          chk("wb_valid", 32'(or_wb_valid), 32'(me.wbv));
          if (me.wbv) begin
            chk("wb_rd", 32'(or_wb_rd), 32'(me.rd));
            chk("wb_data", or_wb_data, me.wbd);
          end
          chk("req_cycles", 32'(reqc), 32'(me.req));
          chk("op_cycles", 32'(opcyc + 1), 32'(me.cyc));
        end
      end
      prev_ready = or_ready;
    end
  end

  task automatic run_op(input logic ld, input logic [2:0] f3, input logic [31:0] base,
                        input logic [31:0] off, input logic [31:0] sd, input logic [4:0] rd,
                        input int delay, input logic [31:0] md);
    int n;
    n = 0;
    @(negedge clk);
    while (!or_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(or_ready), 32'd1);
    ack_delay = delay;
    mem_rdata = md;
    sbq.push_back(model(ld, f3, base, off, sd, rd, delay, md));
    i_is_load = ld; i_funct3 = f3; i_base = base; i_offset = off;
    i_store_data = sd; i_rd = rd; i_valid = 1'b1;
    @(negedge clk);
    // Unit is busy now; this offer must be ignored.
    i_is_load = $urandom_range(0, 1); i_funct3 = 3'($urandom); i_base = $urandom;
    i_offset = $urandom; i_store_data = $urandom; i_rd = 5'($urandom);
    @(negedge clk);
    i_valid = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, dly;
    logic [31:0] off;
    rst_n = 1'b0; i_valid = 1'b0; i_is_load = 1'b0; i_funct3 = '0;
    i_base = '0; i_offset = '0; i_store_data = '0; i_rd = '0;
    i_mem_ack = 1'b0; i_mem_data = '0;
    #1;
    chk("rst_ready", 32'(or_ready), 32'd1);
    chk("rst_req", 32'(or_mem_req), 32'd0);
    chk("rst_done", 32'(or_done), 32'd0);
    chk("rst_wbv", 32'(or_wb_valid), 32'd0);
    chk("rst_fault", 32'(or_fault), 32'd0);
    chk("rst_addr", or_mem_addr, 32'd0);
    chk("rst_wbdata", or_wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b1, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 1, 32'hDEADBEEF);
    run_op(1'b0, 3'b000, 32'h203, 32'h0, 32'h000000AB, 5'd3, 2, 32'h0);
    run_op(1'b1, 3'b010, 32'hFFFFFFFC, 32'h8, 32'h0, 5'd7, 1, 32'h12345678);
    run_op(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 5'd1, NEVER, 32'h0);
    run_op(1'b1, 3'b010, 32'h400, 32'h0, 32'h0, 5'd9, TO, 32'hA5A55A5A);
    run_op(1'b1, 3'b001, 32'h101, 32'h0, 32'h0, 5'd4, 1, 32'hFFFF8001);
    run_op(1'b1, 3'b011, 32'h200, 32'h0, 32'h0, 5'd6, 1, 32'h0);
    run_op(1'b0, 3'b011, 32'h200, 32'h0, 32'h1, 5'd6, 1, 32'h0);
    run_op(1'b1, 3'b100, 32'h10, 32'h3, 32'h0, 5'd0, 3, 32'h000000FF);

    // Reset while a request is outstanding.
    @(negedge clk);
    ack_delay = NEVER;
    i_is_load = 1'b1; i_funct3 = 3'b010; i_base = 32'h40; i_offset = '0; i_rd = 5'd2;
    i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", 32'(or_mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(or_mem_req), 32'd0);
    chk("midrst_ready", 32'(or_ready), 32'd1);
    chk("midrst_done", 32'(or_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 5'd2, 1, 32'h0BADC0DE);

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      dly = (r == 0) ? NEVER : (r == 1) ? TO : $urandom_range(1, 4);
      off = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, off,
             $urandom, 5'($urandom), dly, $urandom);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
